// File: rtl/dcache_direct_wb.sv
// rtl/dcache_direct_wb.sv - direct-mapped write-back write-allocate data cache, 8 x 4-word lines
// Optional hit/miss counters: define DCACHE_STATS_EN to add stat_hit/stat_miss outputs.
module dcache_direct_wb (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         proc_read,
  input  logic         proc_write,
  input  logic [29:0]  proc_addr,
  input  logic [31:0]  proc_wdata,
  output logic         proc_stall,
  output logic [31:0]  proc_rdata,
  output logic         mem_read,
  output logic         mem_write,
  output logic [27:0]  mem_addr,
  output logic [127:0] mem_wdata,
  input  logic [127:0] mem_rdata,
  input  logic         mem_ready
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]  stat_hit,
  output logic [31:0]  stat_miss
`endif
);

  typedef enum logic [1:0] {
    S_COMPARE   = 2'd0,
    S_WRITEBACK = 2'd1,
    S_ALLOCATE  = 2'd2
  } state_e;

  state_e         state_q;
  logic [7:0]     valid_q;
  logic [7:0]     dirty_q;
  logic [24:0]    tag_q  [8];
  logic [127:0]   data_q [8];
  logic           mem_read_q;
  logic           mem_write_q;
  logic [27:0]    mem_addr_q;
  logic [127:0]   mem_wdata_q;

  logic [2:0]     idx;
  logic [1:0]     off;
  logic [24:0]    req_tag;
  logic           req;
  logic           hit;
  logic           in_compare;
  logic [31:0]    sel_word;

  assign idx        = proc_addr[4:2];
  assign off        = proc_addr[1:0];
  assign req_tag    = proc_addr[29:5];
  // A simultaneous read+write is handled as a write.
  assign req        = proc_read | proc_write;
  assign hit        = valid_q[idx] && (tag_q[idx] == req_tag);
  assign in_compare = (state_q == S_COMPARE);
  assign sel_word   = data_q[idx][{off, 5'd0} +: 32];

  // Stall is combinational so hits complete in the request cycle.
  assign proc_stall = !in_compare || (req && !hit);
  assign proc_rdata = (in_compare && proc_read && !proc_write && hit) ? sel_word : 32'd0;

  assign mem_read   = mem_read_q;
  assign mem_write  = mem_write_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  // Miss FSM with registered memory-bus outputs, plus line storage updates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_COMPARE;
      valid_q     <= '0;
      dirty_q     <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      for (int i = 0; i < 8; i++) begin
        tag_q[i]  <= '0;
        data_q[i] <= '0;
      end
    end else begin
      case (state_q)
        S_COMPARE: begin
          if (req) begin
            if (hit) begin
              if (proc_write) begin
                data_q[idx][{off, 5'd0} +: 32] <= proc_wdata;
                dirty_q[idx]                   <= 1'b1;
              end
            end else if (valid_q[idx] && dirty_q[idx]) begin
              state_q     <= S_WRITEBACK;
              mem_write_q <= 1'b1;
              mem_addr_q  <= {tag_q[idx], idx};
              mem_wdata_q <= data_q[idx];
            end else begin
              state_q    <= S_ALLOCATE;
              mem_read_q <= 1'b1;
              mem_addr_q <= {req_tag, idx};
            end
          end
        end
        S_WRITEBACK: begin
          if (mem_ready) begin
            state_q     <= S_ALLOCATE;
            mem_write_q <= 1'b0;
            mem_read_q  <= 1'b1;
            mem_addr_q  <= {req_tag, idx};
            mem_wdata_q <= '0;
          end
        end
        S_ALLOCATE: begin
          if (mem_ready) begin
            state_q      <= S_COMPARE;
            mem_read_q   <= 1'b0;
            mem_addr_q   <= '0;
            data_q[idx]  <= mem_rdata;
            tag_q[idx]   <= req_tag;
            valid_q[idx] <= 1'b1;
            dirty_q[idx] <= 1'b0;
          end
        end
        default: begin
          state_q <= S_COMPARE;
        end
      endcase
    end
  end

`ifdef DCACHE_STATS_EN
  logic        refill_q;
  logic [31:0] stat_hit_q;
  logic [31:0] stat_miss_q;

  assign stat_hit  = stat_hit_q;
  assign stat_miss = stat_miss_q;

  // Count first-look hits and misses; the hit that follows a refill is not a new hit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      refill_q    <= 1'b0;
      stat_hit_q  <= '0;
      stat_miss_q <= '0;
    end else begin
      refill_q <= (state_q == S_ALLOCATE) && mem_ready;
      if (in_compare && req && hit && !refill_q) begin
        stat_hit_q <= stat_hit_q + 32'd1;
      end
      if (in_compare && req && !hit) begin
        stat_miss_q <= stat_miss_q + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dcache_direct_wb.sv
// tb/tb_dcache_direct_wb.sv - self-checking bench for dcache_direct_wb against a memory-view model
module tb_dcache_direct_wb;

  logic         clk;
  logic         rst_n;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;
`ifdef DCACHE_STATS_EN
  logic [31:0]  stat_hit;
  logic [31:0]  stat_miss;
`endif

  int vectors;
  int fails;

  // Main memory contents that have been written back; untouched blocks follow init_word.
  logic [127:0] mem_blk [logic [27:0]];
  // Words stored by the core that may not yet be in main memory.
  logic [31:0]  written [logic [29:0]];
  // Which block each index currently holds, and whether it holds unwritten stores.
  bit           cv [8];
  bit           cd [8];
  logic [24:0]  ctag [8];
  int           m_hits;
  int           m_miss;

  dcache_direct_wb dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .proc_read  (proc_read),
    .proc_write (proc_write),
    .proc_addr  (proc_addr),
    .proc_wdata (proc_wdata),
    .proc_stall (proc_stall),
    .proc_rdata (proc_rdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready)
`ifdef DCACHE_STATS_EN
    ,
    .stat_hit   (stat_hit),
    .stat_miss  (stat_miss)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input logic [29:0] a);
    logic [31:0] p;
    p = {2'b00, a} * 32'h9E37_79B9;
    return p ^ 32'h5A5A_0000;
  endfunction

  function automatic logic [127:0] mem_block(input logic [27:0] b);
    logic [127:0] r;
    if (mem_blk.exists(b)) return mem_blk[b];
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = init_word({b, 2'(i)});
    return r;
  endfunction

  function automatic logic [31:0] truth_word(input logic [29:0] a);
    logic [127:0] blk;
    if (written.exists(a)) return written[a];
    blk = mem_block(a[29:2]);
    return blk[int'(a[1:0])*32 +: 32];
  endfunction

  function automatic logic [127:0] truth_block(input logic [27:0] b);
    logic [127:0] r;
    for (int i = 0; i < 4; i++) r[i*32 +: 32] = truth_word({b, 2'(i)});
    return r;
  endfunction

  function automatic logic [127:0] garbage();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    vectors++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) begin
      cv[i] = 1'b0;
      cd[i] = 1'b0;
      ctag[i] = '0;
    end
    written.delete();
    m_hits = 0;
    m_miss = 0;
  endtask

  // One core request held until stall drops; acts as main memory with the given latencies.
  task automatic access(input bit rd, input bit wr, input logic [29:0] a, input logic [31:0] wd,
                        input int lat_wb, input int lat_al);
    logic [2:0]   idx;
    logic [24:0]  tag;
    bit           exp_hit;
    bit           exp_dirty;
    int           exp_stall;
    logic [27:0]  wb_addr;
    logic [127:0] wb_data;
    int           stalls;
    int           wcnt;
    bit           done;
    idx       = a[4:2];
    tag       = a[29:5];
    exp_hit   = cv[idx] && (ctag[idx] == tag);
    exp_dirty = !exp_hit && cv[idx] && cd[idx];
    exp_stall = exp_hit ? 0 : (1 + (exp_dirty ? lat_wb + 1 : 0) + lat_al + 1);
    wb_addr   = {ctag[idx], idx};
    wb_data   = truth_block(wb_addr);
    proc_read  = rd;
    proc_write = wr;
    proc_addr  = a;
    proc_wdata = wd;
    stalls = 0;
    wcnt   = 0;
    done   = 1'b0;
    for (int cyc = 0; cyc < 40 && !done; cyc++) begin
      @(negedge clk);
      if (!proc_stall) begin
        done = 1'b1;
        if (rd && !wr) check("rdata", proc_rdata, truth_word(a));
      end else begin
        stalls++;
        check("strobe_excl", mem_read && mem_write, 0);
        if (mem_write) begin
          if (wcnt == 0) begin
            check("wb_addr", mem_addr, wb_addr);
            check("wb_data", mem_wdata, wb_data);
          end
          if (wcnt == lat_wb) begin
            mem_ready = 1'b1;
            mem_blk[mem_addr] = mem_wdata;
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end else if (mem_read) begin
          if (wcnt == 0) check("alloc_addr", mem_addr, {tag, idx});
          if (wcnt == lat_al) begin
            mem_ready = 1'b1;
            mem_rdata = mem_block(mem_addr);
            wcnt = 0;
          end else begin
            wcnt++;
          end
        end
      end
      @(posedge clk);
      #1;
      mem_ready = 1'b0;
      mem_rdata = garbage();
    end
    if (!done) check("timeout", 0, 1);
    check("stall_cycles", stalls, exp_stall);
    if (exp_hit) m_hits++;
    else m_miss++;
    if (!exp_hit) begin
      cv[idx]   = 1'b1;
      cd[idx]   = 1'b0;
      ctag[idx] = tag;
    end
    if (wr) begin
      written[a] = wd;
      cd[idx]    = 1'b1;
    end
    proc_read  = 1'b0;
    proc_write = 1'b0;
  endtask

  task automatic idle_cycle();
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = 30'($urandom);
    mem_ready  = 1'b1;
    @(negedge clk);
    check("idle_stall", proc_stall, 0);
    check("idle_strobes", {mem_read, mem_write}, 0);
    @(posedge clk);
    #1;
    mem_ready = 1'b0;
  endtask

  initial begin
    int seen;
    vectors    = 0;
    fails      = 0;
    rst_n      = 1'b0;
    proc_read  = 1'b0;
    proc_write = 1'b0;
    proc_addr  = '0;
    proc_wdata = '0;
    mem_rdata  = '0;
    mem_ready  = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_wdata, 0);
    check("rst_stall", proc_stall, 0);
    check("rst_rdata", proc_rdata, 0);
`ifdef DCACHE_STATS_EN
    check("rst_stat_hit", stat_hit, 0);
    check("rst_stat_miss", stat_miss, 0);
`endif
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Cold read, then a hit on the same block, then write hit and readback.
    access(1, 0, 30'h10, 32'h0, 0, 2);
    access(1, 0, 30'h11, 32'h0, 0, 0);
    access(0, 1, 30'h12, 32'hDEAD_BEEF, 0, 0);
    access(1, 0, 30'h12, 32'h0, 0, 0);
`ifdef DCACHE_STATS_EN
    check("stat_hit_seq", stat_hit, 3);
    check("stat_miss_seq", stat_miss, 1);
`endif
    // Dirty eviction of index 4, with both fastest and slower memory.
    access(1, 0, 30'h32, 32'h0, 0, 0);
    access(0, 1, 30'h31, 32'h1234_5678, 0, 0);
    access(1, 0, 30'h13, 32'h0, 2, 1);
    // Write miss to a clean line, then read every word of that block.
    access(0, 1, 30'h45, 32'hCAFE_F00D, 0, 1);
    for (int w = 0; w < 4; w++) access(1, 0, 30'h44 + 30'(w), 32'h0, 0, 0);
    idle_cycle();

    // Reset while a refill is outstanding.
    access(1, 0, 30'h08, 32'h0, 0, 0);
    proc_read = 1'b1;
    proc_addr = 30'h7C;
    seen = 0;
    for (int cyc = 0; cyc < 10 && seen == 0; cyc++) begin
      @(negedge clk);
      if (mem_read) seen = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    check("alloc_seen", seen, 1);
    rst_n = 1'b0;
    #1;
    check("rst_mid_mem_read", mem_read, 0);
    check("rst_mid_mem_write", mem_write, 0);
    proc_read = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    access(1, 0, 30'h08, 32'h0, 0, 0);

    // Random traffic over a few tags so hits, clean misses and evictions all occur.
    for (int n = 0; n < 300; n++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op == 0) idle_cycle();
      else access(op < 5 || op == 9, op >= 5, 30'($urandom_range(0, 127)), $urandom,
                  $urandom_range(0, 3), $urandom_range(0, 3));
    end
`ifdef DCACHE_STATS_EN
    check("stat_hit_end", stat_hit, m_hits);
    check("stat_miss_end", stat_miss, m_miss);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule

// File: doc/dcache_direct_wb.md
# dcache_direct_wb

Direct-mapped, write-back, write-allocate data cache between the pipelined MIPS core's D-cache port and the slow main-memory bus. Hits complete with zero stall. Misses hold `proc_stall` high while a miss FSM writes back any dirty victim and refills the 4-word block. The identical module also serves as the instruction cache (wen tied low).

## Interface
- `WORDS_PER_BLOCK`, 4: fixed. Block = 128 bits; word offset = `proc_addr[1:0]`.
- `NUM_BLOCKS`, 8: fixed. Index = `proc_addr[4:2]`; tag = `proc_addr[29:5]` (25 bits).
- `clk`  in  1  clock; all state updates on posedge.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `proc_read`  in  1  core read request (level, held while stalled).
- `proc_write`  in  1  core write request (level, held while stalled).
- `proc_addr`  in  30  word address.
- `proc_wdata`  in  32  store data.
- `proc_stall`  out  1  combinational; high while request not yet satisfied.
- `proc_rdata`  out  32  combinational read data; valid when `proc_read` is high and `proc_stall` is low.
- `mem_read`  out  1  block refill request.
- `mem_write`  out  1  block write-back request.
- `mem_addr`  out  28  block address {tag, index}.
- `mem_wdata`  out  128  victim block; word0 in [31:0].
- `mem_rdata`  in  128  refill data; valid with `mem_ready`.
- `mem_ready`  in  1  one-cycle pulse completing the current mem request.

## Operation
- Per line storage: valid, dirty, tag[24:0], data[127:0].
- Both `proc_read` and `proc_write` high is illegal. The request is treated as a write, and `proc_rdata` is don't-care.
- FSM states: COMPARE, WRITEBACK, ALLOCATE.
- COMPARE, no request: `proc_stall`=0, no state change.
- COMPARE, hit (valid && tag match):
  - `proc_stall`=0.
  - Read: `proc_rdata` = selected word.
  - Write: on the clock edge, the selected word is replaced and dirty is set.
- COMPARE, miss: `proc_stall`=1.
  - Victim valid and dirty: go to WRITEBACK.
  - Otherwise: go to ALLOCATE.
- WRITEBACK:
  - `mem_write`=1, `mem_addr`={victim tag, index}, `mem_wdata`=victim data.
  - Hold until `mem_ready`, then go to ALLOCATE.
- ALLOCATE:
  - `mem_read`=1, `mem_addr`={req tag, index}.
  - On `mem_ready`: line data = `mem_rdata`, tag = req tag, valid=1, dirty=0; go to COMPARE.
  - The request then hits in COMPARE. Write merge happens in that hit cycle.
- `mem_read` and `mem_write` are never high together. Both are 0 in COMPARE.
- `mem_rdata` is ignored unless state is ALLOCATE and `mem_ready`=1. `mem_ready` in COMPARE is ignored.

## Timing
- Reset: state=COMPARE; all valid=0, dirty=0. `mem_read`=0, `mem_write`=0, `mem_addr`=0, `mem_wdata`=0. `proc_stall`=0 when no request, and `proc_rdata`=0.
- Hit latency: 0 stall cycles.
- Clean miss stall: 1 (COMPARE) + N_alloc cycles + 1 (COMPARE hit cycle, stall low). N_alloc = cycles up to and including `mem_ready`.
- Dirty miss adds N_wb cycles of WRITEBACK before ALLOCATE.
- With `mem_ready` asserted on the first request cycle: clean miss = 2 stalled cycles; dirty miss = 3 stalled cycles.
- The core must hold address and data stable while `proc_stall`=1. The cache latches nothing from the core.
- Reset asserted mid-miss: FSM returns to COMPARE immediately, memory request drops, all lines invalid. Any pending write is lost.

## Configuration
- `DCACHE_STATS_EN`:
  - Defined: adds outputs `stat_hit` [31:0] and `stat_miss` [31:0]. Both reset to 0 and wrap at 2^32.
  - `stat_hit` increments on each COMPARE cycle with a request and a hit, except the post-refill hit cycle.
  - `stat_miss` increments once per miss, on COMPARE-to-WRITEBACK or COMPARE-to-ALLOCATE.
  - Undefined: ports and counters absent; behaviour otherwise identical.

## Test plan
- Cold read 0x0000_0010 (index 4, offset 0) with memory block = {D,C,B,A}:
  - `mem_read` high with `mem_addr`=0x0000004.
  - After `mem_ready`, `proc_rdata`=A with stall low.
  - Repeat read of 0x11 returns B with zero stall.
- Write hit: after the refill above, write 0xDEADBEEF to 0x12.
  - No stall.
  - Read 0x12 returns 0xDEADBEEF; dirty set.
- Dirty eviction: read 0x32 (same index 4, new tag).
  - WRITEBACK: `mem_addr`=0x0000004, `mem_wdata`={D,0xDEADBEEF,B,A}.
  - Then ALLOCATE: `mem_addr`=0x000000C.
  - Never both mem strobes high.
- Write miss to clean line:
  - No write-back.
  - After refill, the written word is merged, and the other three words equal `mem_rdata`.
- Reset during ALLOCATE:
  - `mem_read` drops within the reset; the previously cached address misses afterward.
- `DCACHE_STATS_EN` defined, sequence hit, hit, miss: `stat_hit`=2, `stat_miss`=1.
